// File: rtl/pd_pkg.sv
// Shared widths and word type for the packet-identifier datapath.
package pd_pkg;

  localparam int unsigned PD_DATA_W = 512;
  localparam int unsigned PD_DK_W   = PD_DATA_W / 8;

  typedef struct packed {
    logic [PD_DATA_W-1:0] data;
    logic [PD_DK_W-1:0]   dk;
  } pd_word_t;

endpackage

// File: rtl/pd_fifo_mem.sv
// Elastic-buffer storage: DEPTH words, one write port, one read port, wrapping pointers.
module pd_fifo_mem #(
  parameter int unsigned WIDTH = 576,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Read port looks at the head as it will be after this edge's pop.
  always_comb begin
    rd_addr = rd_ptr_q + AW'(rd_en);
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/pd_elastic_buffer.sv
// DEPTH-entry elastic buffer carrying data plus per-byte D/K flags, with a registered
// output stage, valid/ready handshake, hold, flush, occupancy and almost-full.
module pd_elastic_buffer
  import pd_pkg::*;
#(
  parameter int unsigned DATA_W    = PD_DATA_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [DATA_W/8-1:0]    DK_in,
  input  logic                   hld_pd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      data_out,
  output logic [DATA_W/8-1:0]    DK_out,
  output logic                   hld_out,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int unsigned DK_W = DATA_W / 8;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfullC = CW'(AFULL_LVL);

  logic                   full, push, pop;
  logic [CW-1:0]          count_q, count_d, remaining;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DK_W-1:0]        dk_q, dk_d;
  logic [DK_W+DATA_W-1:0] rd_word;
  logic                   hld_q;

  always_comb begin
    full     = (count_q == DepthC);
    in_ready = ~full & ~flush & ~rst;
    push     = in_valid & in_ready;
    pop      = out_valid_q & out_ready & ~hld_pd;
  end

  pd_fifo_mem #(
    .WIDTH (DK_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (push),
    .wr_data ({DK_in, data_in}),
    .rd_en   (pop),
    .rd_data (rd_word)
  );

  always_comb begin
    remaining = count_q - CW'(pop);
    count_d   = flush ? '0 : remaining + CW'(push);
  end

  // Output register mirrors the head word; when nothing else is stored behind the pop,
  // the head is the word being pushed right now.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    dk_d        = dk_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (!hld_pd) begin
      if (count_d == '0) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        if (remaining == '0) begin
          data_d = data_in;
          dk_d   = DK_in;
        end else begin
          data_d = rd_word[DATA_W-1:0];
          dk_d   = rd_word[DK_W+DATA_W-1:DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      dk_q        <= '0;
      hld_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      dk_q        <= dk_d;
      hld_q       <= hld_pd;
    end
  end

  always_comb begin
    out_valid   = out_valid_q;
    data_out    = data_q;
    DK_out      = dk_q;
    hld_out     = hld_q;
    count       = count_q;
    almost_full = (count_q >= AfullC);
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));
  a_count_bound  : assert property (@(posedge clk) disable iff (rst) count_q <= DepthC);

endmodule
